// File: rtl/data_memory_ws.sv
// Single-port data memory with req/ack handshake, programmable wait states
// and an optional post-reset clear sweep that zeroes every word.
module data_memory_ws #(
  parameter int WIDTH          = 16,
  parameter int REGBITS        = 8,
  parameter int WAIT_STATES    = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               wr,
  input  logic [REGBITS-1:0] addr,
  input  logic [WIDTH-1:0]   w_data,
  output logic [WIDTH-1:0]   r_data,
  output logic               ack,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int                 WCNT_W    = 4;
  localparam logic [WCNT_W-1:0]  WAIT_LAST = WCNT_W'(WAIT_STATES - 32'sd1);
  localparam logic [REGBITS-1:0] CLR_LAST  = {REGBITS{1'b1}};
  localparam bit                 HAS_WAIT  = (WAIT_STATES != 32'sd0);

  logic [WIDTH-1:0]   mem [2**REGBITS];
  state_t             state_r, next_state_s;
  logic [WCNT_W-1:0]  wcnt_r;
  logic [REGBITS-1:0] clr_cnt_r;
  logic               lat_wr_r;
  logic [REGBITS-1:0] lat_addr_r;
  logic [WIDTH-1:0]   lat_data_r;
  logic               ack_r, busy_r;
  logic [WIDTH-1:0]   r_data_r;
  logic               acc_wr_s;
  logic [REGBITS-1:0] acc_addr_s;
  logic [WIDTH-1:0]   acc_data_s;
  logic               mem_we_s, rd_load_s;
  logic [REGBITS-1:0] mem_waddr_s;
  logic [WIDTH-1:0]   mem_wdata_s;

  // State register, counters, request latch and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      wcnt_r     <= {WCNT_W{1'b0}};
      clr_cnt_r  <= {REGBITS{1'b0}};
      lat_wr_r   <= 1'b0;
      lat_addr_r <= {REGBITS{1'b0}};
      lat_data_r <= {WIDTH{1'b0}};
      ack_r      <= 1'b0;
      busy_r     <= 1'b1;
      r_data_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      ack_r   <= (next_state_s == ST_RESP);
      busy_r  <= (next_state_s != ST_IDLE);
      if (state_r == ST_INIT) clr_cnt_r <= clr_cnt_r + 1'b1;
      if (state_r == ST_WAIT) wcnt_r <= wcnt_r + 1'b1;
      else                    wcnt_r <= {WCNT_W{1'b0}};
      if (state_r == ST_IDLE && req == 1'b1) begin
        lat_wr_r   <= wr;
        lat_addr_r <= addr;
        lat_data_r <= w_data;
      end
      if (rd_load_s) r_data_r <= mem[acc_addr_s];
    end
  end

  // Next-state logic; req is only examined in IDLE so an X elsewhere is inert
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (clr_cnt_r == CLR_LAST) next_state_s = ST_IDLE;
        else                       next_state_s = ST_INIT;
      end
      ST_IDLE: begin
        if (req == 1'b1) next_state_s = HAS_WAIT ? ST_WAIT : ST_RESP;
        else             next_state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (wcnt_r == WAIT_LAST) next_state_s = ST_RESP;
        else                     next_state_s = ST_WAIT;
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Access datapath: the access completes on the edge that enters RESP
  always_comb begin
    acc_wr_s    = lat_wr_r;
    acc_addr_s  = lat_addr_r;
    acc_data_s  = lat_data_r;
    mem_we_s    = 1'b0;
    rd_load_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      acc_wr_s   = wr;
      acc_addr_s = addr;
      acc_data_s = w_data;
    end else begin
      acc_wr_s   = lat_wr_r;
    end
    mem_waddr_s = acc_addr_s;
    mem_wdata_s = acc_data_s;
    if (state_r == ST_INIT) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_cnt_r;
      mem_wdata_s = {WIDTH{1'b0}};
    end else if (next_state_s == ST_RESP) begin
      mem_we_s  = (acc_wr_s == 1'b1);
      rd_load_s = (acc_wr_s == 1'b0);
    end else begin
      mem_we_s  = 1'b0;
    end
  end

  // Storage array; reset blocks any write so a pending access is dropped
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) mem[mem_waddr_s] <= mem_wdata_s;
  end

  assign r_data = r_data_r;
  assign ack    = ack_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_data_memory_ws.sv
// Scoreboard bench for data_memory_ws: three instances cover wait states,
// clear sweep, reset mid-access and back-to-back throughput.
module tb_data_memory_ws;

  logic        clk = 1'b0;
  logic [2:0]  reset, req, wr, ack, busy;
  logic [7:0]  addr   [3];
  logic [15:0] w_data [3];
  logic [15:0] r_data [3];

  typedef struct {
    int          inst;
    int          cyc;
    logic [15:0] rd;
  } exp_t;

  exp_t        sbq [$];
  logic [15:0] last_rd [3];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          nb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // inst 0: WS=1 clear; inst 1: WS=1 no clear; inst 2: WS=0 clear
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_ws #(
      .WIDTH(16), .REGBITS(8),
      .WAIT_STATES(g == 2 ? 0 : 1),
      .CLEAR_ON_RESET(g == 1 ? 1'b0 : 1'b1)
    ) u_dut (
      .clk(clk), .reset(reset[g]), .req(req[g]), .wr(wr[g]),
      .addr(addr[g]), .w_data(w_data[g]), .r_data(r_data[g]),
      .ack(ack[g]), .busy(busy[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // Issue one access; expected completion cycle and r_data go to the scoreboard
  task automatic access(input int i, input bit w, input logic [7:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input bit hold, input bit scramble);
    int   guard;
    exp_t e;
    guard = 0;
    while (busy[i] !== 1'b0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (busy[i] !== 1'b0) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout inst=%0d actual busy=%b required 0", i, busy[i]);
      return;
    end
    req[i] = 1'b1; wr[i] = w; addr[i] = a; w_data[i] = d;
    e.inst = i;
    e.cyc  = cyc + ((i == 2) ? 0 : 1) + 1;
    e.rd   = w ? last_rd[i] : exp_rd;
    sbq.push_back(e);
    if (!w) last_rd[i] = exp_rd;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (scramble && guard == 1) begin
        addr[i] = 8'h06; w_data[i] = 16'h5555;
      end
    end while (ack[i] !== 1'b1 && guard < 20);
    if (ack[i] !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL ack_timeout inst=%0d actual ack=%b required 1", i, ack[i]);
    end
    if (!hold) req[i] = 1'b0;
  endtask

  // Monitor: every ack must match the oldest pending entry for that instance
  always @(negedge clk) begin
    if (cyc > 2 && $isunknown({ack, busy})) begin
      n_err++;
      $display("FAIL x_on_handshake actual ack=%b busy=%b required known", ack, busy);
    end
    for (int i = 0; i < 3; i++) begin
      if (ack[i] === 1'b1) begin
        int idx;
        idx = -1;
        for (int k = 0; k < sbq.size(); k++)
          if (idx < 0 && sbq[k].inst == i) idx = k;
        n_cmp++;
        if (idx < 0) begin
          n_err++;
          $display("FAIL unexpected_ack inst=%0d cyc=%0d actual ack=1 required 0", i, cyc);
        end else begin
          if (sbq[idx].cyc != cyc || r_data[i] !== sbq[idx].rd) begin
            n_err++;
            $display("FAIL ack_resp inst=%0d actual cyc=%0d r_data=%h required cyc=%0d r_data=%h",
                     i, cyc, r_data[i], sbq[idx].cyc, sbq[idx].rd);
          end
          sbq.delete(idx);
        end
      end
    end
  end

  initial begin
    reset = 3'b111; req = 3'b001; wr = 3'b001;
    for (int i = 0; i < 3; i++) begin
      addr[i] = 8'h00; w_data[i] = 16'h0000; last_rd[i] = 16'h0000;
    end
    // inst 0 holds a write request through reset and the whole sweep
    addr[0] = 8'h30; w_data[0] = 16'hFFFF;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy%0d", i), {31'd0, busy[i]}, 32'd1);
      check($sformatf("rst_ack%0d", i), {31'd0, ack[i]}, 32'd0);
      check($sformatf("rst_rdata%0d", i), {16'd0, r_data[i]}, 32'd0);
    end
    reset = 3'b000;

    nb = 0;
    while (busy[0] === 1'b1 && nb < 300) begin
      nb++;
      @(negedge clk);
    end
    check("init_busy_cycles", nb, 32'd256);

    access(0, 1'b1, 8'h30, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    access(0, 1'b0, 8'hFF, 16'h0000, 16'h0000, 1'b0, 1'b0);
    access(0, 1'b0, 8'h30, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    access(0, 1'b0, 8'h31, 16'h0000, 16'h0000, 1'b0, 1'b0);
    access(0, 1'b1, 8'h12, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    access(0, 1'b0, 8'h12, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    access(0, 1'b1, 8'h12, 16'h1234, 16'h0000, 1'b0, 1'b0);
    access(0, 1'b0, 8'h12, 16'h0000, 16'h1234, 1'b0, 1'b0);
    access(0, 1'b1, 8'h05, 16'hAAAA, 16'h0000, 1'b0, 1'b1);
    access(0, 1'b0, 8'h05, 16'h0000, 16'hAAAA, 1'b0, 1'b0);
    access(0, 1'b0, 8'h06, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Reset lands in the WAIT cycle of a write: it must vanish without ack
    access(1, 1'b1, 8'h20, 16'h1111, 16'h0000, 1'b0, 1'b0);
    access(1, 1'b0, 8'h20, 16'h0000, 16'h1111, 1'b0, 1'b0);
    nb = 0;
    while (busy[1] !== 1'b0 && nb < 20) begin
      @(negedge clk);
      nb++;
    end
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 8'h20; w_data[1] = 16'hCAFE;
    @(negedge clk);
    check("wait_busy", {31'd0, busy[1]}, 32'd1);
    reset[1] = 1'b1; req[1] = 1'b0;
    @(negedge clk);
    check("midrst_ack", {31'd0, ack[1]}, 32'd0);
    check("midrst_rdata", {16'd0, r_data[1]}, 32'd0);
    reset[1] = 1'b0; last_rd[1] = 16'h0000;
    access(1, 1'b0, 8'h20, 16'h0000, 16'h1111, 1'b0, 1'b0);

    // Zero wait states: reads with req held high complete every 2nd cycle
    access(2, 1'b1, 8'h01, 16'h0101, 16'h0000, 1'b0, 1'b0);
    access(2, 1'b1, 8'h02, 16'h0202, 16'h0000, 1'b0, 1'b0);
    access(2, 1'b1, 8'h03, 16'h0303, 16'h0000, 1'b0, 1'b0);
    access(2, 1'b0, 8'h01, 16'h0000, 16'h0101, 1'b1, 1'b0);
    access(2, 1'b0, 8'h02, 16'h0000, 16'h0202, 1'b1, 1'b0);
    access(2, 1'b0, 8'h03, 16'h0000, 16'h0303, 1'b0, 1'b0);

    repeat (6) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
